decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_pkg.sv | 27 ++
 rtl/instr_decoder.sv | 84 ++++++++
 rtl/decode_stage.sv | 122 ++++++++++++
 tb/tb_decode_stage.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared encodings for the decode stage: MIPS-I opcode/funct values, the
// ALU operation set handed to execute, and the hard-wired zero register.
package decode_pkg;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_SLT = 4'd5
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational instruction decode: ALU op, destination, control flags
// and sign-extended immediate for the supported MIPS-I subset.
module instr_decoder
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output alu_op_t     alu_op,
  output logic [4:0]  dst,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        illegal,
  output logic        use_imm,
  output logic        rt_used,
  output logic [31:0] imm
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_shamt;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign unused_shamt = ^instr[10:6];

  assign imm = {{16{instr[15]}}, instr[15:0]};

  // rt is a source operand for R-type and for the sw store data
  assign rt_used = (opcode == OP_RTYPE) || (opcode == OP_SW);

  always_comb begin
    alu_op    = ALU_NOP;
    dst       = REG_ZERO;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    illegal   = 1'b0;
    use_imm   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dst       = rd;
        reg_write = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: begin
            illegal   = 1'b1;
            reg_write = 1'b0;
            dst       = REG_ZERO;
          end
        endcase
      end
      OP_ADDI: begin
        alu_op    = ALU_ADD;
        dst       = rt;
        reg_write = 1'b1;
        use_imm   = 1'b1;
      end
      OP_LW: begin
        alu_op    = ALU_ADD;
        dst       = rt;
        reg_write = 1'b1;
        mem_read  = 1'b1;
        use_imm   = 1'b1;
      end
      OP_SW: begin
        alu_op    = ALU_ADD;
        mem_write = 1'b1;
        use_imm   = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    // writes to $0 are architecturally void
    if (dst == REG_ZERO) reg_write = 1'b0;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: register read with write-back bypass, load-use
// hazard detection, and a single output slot with valid/ready handshake.
module decode_stage
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset_b,
  input  logic        flush,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  output logic        id_ready,
  output logic [4:0]  rd_reg1,
  output logic [4:0]  rd_reg2,
  input  logic [31:0] rd_data1,
  input  logic [31:0] rd_data2,
  input  logic        wb_write,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [3:0]  ex_alu_op,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_dst,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_illegal
);

  alu_op_t     dec_alu_op;
  logic [4:0]  dec_dst;
  logic        dec_reg_write;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_illegal;
  logic        dec_use_imm;
  logic        dec_rt_used;
  logic [31:0] dec_imm;

  logic [4:0]  src_reg  [2];
  logic [31:0] src_data [2];
  logic [31:0] opnd     [2];

  logic        adv;
  logic        stall;
  logic        accept;

  assign rd_reg1 = if_instr[25:21];
  assign rd_reg2 = if_instr[20:16];

  assign src_reg[0]  = rd_reg1;
  assign src_reg[1]  = rd_reg2;
  assign src_data[0] = rd_data1;
  assign src_data[1] = rd_data2;

  instr_decoder u_dec (
    .instr     (if_instr),
    .alu_op    (dec_alu_op),
    .dst       (dec_dst),
    .reg_write (dec_reg_write),
    .mem_read  (dec_mem_read),
    .mem_write (dec_mem_write),
    .illegal   (dec_illegal),
    .use_imm   (dec_use_imm),
    .rt_used   (dec_rt_used),
    .imm       (dec_imm)
  );

  // Same-cycle write-back wins over the register file; $0 is forced to zero last.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      always_comb begin
        opnd[gi] = src_data[gi];
        if (wb_write && (wb_reg != REG_ZERO) && (wb_reg == src_reg[gi]))
          opnd[gi] = wb_data;
        if (src_reg[gi] == REG_ZERO)
          opnd[gi] = '0;
      end
    end
  endgenerate

  assign adv   = !ex_valid || ex_ready;
  assign stall = ex_valid && ex_mem_read && (ex_dst != REG_ZERO) &&
                 ((ex_dst == rd_reg1) || (dec_rt_used && (ex_dst == rd_reg2)));

  assign id_ready = reset_b && adv && !stall && !flush;
  assign accept   = if_valid && id_ready;

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      ex_valid      <= 1'b0;
      ex_alu_op     <= '0;
      ex_a          <= '0;
      ex_b          <= '0;
      ex_store_data <= '0;
      ex_dst        <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_illegal    <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid      <= 1'b1;
      ex_alu_op     <= dec_alu_op;
      ex_a          <= opnd[0];
      ex_b          <= dec_use_imm ? dec_imm : opnd[1];
      ex_store_data <= opnd[1];
      ex_dst        <= dec_dst;
      ex_reg_write  <= dec_reg_write;
      ex_mem_read   <= dec_mem_read;
      ex_mem_write  <= dec_mem_write;
      ex_illegal    <= dec_illegal;
    end else if (adv) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus queues expected slots, a
// negedge monitor checks every presented slot and per-cycle handshake values.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk;
  logic        reset_b;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        id_ready;
  logic [4:0]  rd_reg1;
  logic [4:0]  rd_reg2;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;
  logic        wb_write;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        ex_ready;
  logic        ex_valid;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_dst;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_illegal;

  decode_stage dut (
    .clk           (clk),
    .reset_b       (reset_b),
    .flush         (flush),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .id_ready      (id_ready),
    .rd_reg1       (rd_reg1),
    .rd_reg2       (rd_reg2),
    .rd_data1      (rd_data1),
    .rd_data2      (rd_data2),
    .wb_write      (wb_write),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .ex_ready      (ex_ready),
    .ex_valid      (ex_valid),
    .ex_alu_op     (ex_alu_op),
    .ex_a          (ex_a),
    .ex_b          (ex_b),
    .ex_store_data (ex_store_data),
    .ex_dst        (ex_dst),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_illegal    (ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rf [32];
  assign rd_data1 = rf[rd_reg1];
  assign rd_data2 = rf[rd_reg2];

  typedef struct {
    string       nm;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [4:0]  dst;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        ill;
    bit          chk_b;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    exp_rdy  = -1;
  int    exp_v    = -1;
  bit    exp_zero = 0;
  bit    drop     = 0;
  bit    done     = 0;
  string tag      = "init";

  function automatic exp_t mk(string nm, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                              logic [31:0] sd, logic [4:0] dst, logic rw, logic mr,
                              logic mw, logic ill, bit chk_b);
    exp_t e;
    e.nm = nm; e.op = op; e.a = a; e.b = b; e.sd = sd; e.dst = dst;
    e.rw = rw; e.mr = mr; e.mw = mw; e.ill = ill; e.chk_b = chk_b;
    return e;
  endfunction

  // Monitor: all comparisons and counters live in this one process
  always @(negedge clk) begin
    exp_t e;
    if (drop && sb.size() > 0) void'(sb.pop_front());
    if (exp_rdy >= 0) begin
      n_checks++;
      if (id_ready !== exp_rdy[0]) begin
        n_fail++;
        $display("FAIL id_ready [%s]: got %b, expected %0d", tag, id_ready, exp_rdy);
      end
    end
    if (exp_v >= 0) begin
      n_checks++;
      if (ex_valid !== exp_v[0]) begin
        n_fail++;
        $display("FAIL ex_valid [%s]: got %b, expected %0d", tag, ex_valid, exp_v);
      end
    end
    if (exp_zero) begin
      n_checks++;
      if ({id_ready, ex_valid, ex_alu_op, ex_a, ex_b, ex_store_data, ex_dst,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal} !== '0) begin
        n_fail++;
        $display("FAIL reset_zero [%s]: got rdy=%b v=%b op=%0d a=%h b=%h sd=%h dst=%0d flags=%b%b%b%b, expected all 0",
                 tag, id_ready, ex_valid, ex_alu_op, ex_a, ex_b, ex_store_data, ex_dst,
                 ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal);
      end
    end
    if (reset_b === 1'b1 && ex_valid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_slot [%s]: got valid slot op=%0d a=%h dst=%0d, expected none",
                 tag, ex_alu_op, ex_a, ex_dst);
      end else begin
        e = sb[0];
        if (ex_alu_op !== e.op || ex_a !== e.a || (e.chk_b && ex_b !== e.b) ||
            ex_store_data !== e.sd || ex_dst !== e.dst || ex_reg_write !== e.rw ||
            ex_mem_read !== e.mr || ex_mem_write !== e.mw || ex_illegal !== e.ill) begin
          n_fail++;
          $display("FAIL slot %s [%s]: got op=%0d a=%h b=%h sd=%h dst=%0d rw/mr/mw/ill=%b%b%b%b, expected op=%0d a=%h b=%h sd=%h dst=%0d rw/mr/mw/ill=%b%b%b%b",
                   e.nm, tag, ex_alu_op, ex_a, ex_b, ex_store_data, ex_dst,
                   ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal,
                   e.op, e.a, e.b, e.sd, e.dst, e.rw, e.mr, e.mw, e.ill);
        end else begin
          $display("slot %s [%s] ok%s", e.nm, tag, ex_ready ? " (taken)" : " (held)");
        end
        if (ex_ready === 1'b1) void'(sb.pop_front());
      end
    end
    if (done) begin
      n_checks++;
      if (sb.size() != 0) begin
        n_fail++;
        $display("FAIL scoreboard_drain: got %0d pending slots, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end of test");
    $fatal(1, "timeout");
  end

  task automatic cyc(input string t, input int rdy, input int v, input bit z);
    tag      = t;
    exp_rdy  = rdy;
    exp_v    = v;
    exp_zero = z;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I_ADD3  = 32'h0022_1820;
  localparam logic [31:0] I_LW4   = 32'h8C24_FFFC;
  localparam logic [31:0] I_ADD5  = 32'h0082_2820;
  localparam logic [31:0] I_ADD6  = 32'h0022_3020;
  localparam logic [31:0] I_ADD7  = 32'h0041_3820;
  localparam logic [31:0] I_ADDI  = 32'h2022_0001;
  localparam logic [31:0] I_ILL   = 32'hFC22_0000;
  localparam logic [31:0] I_LW4Z  = 32'h8C24_0000;

  logic [31:0] vec_instr [6];
  exp_t        vec_exp   [6];

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    rf[4] = 32'd9;
    reset_b  = 1'b0;
    flush    = 1'b0;
    if_valid = 1'b0;
    if_instr = '0;
    wb_write = 1'b0;
    wb_reg   = '0;
    wb_data  = '0;
    ex_ready = 1'b1;

    cyc("reset0", 0, -1, 0);
    cyc("reset1", 0, 0, 1);

    reset_b = 1'b1;
    cyc("idle", 1, 0, 0);

    // add then load-use pair
    if_valid = 1'b1; if_instr = I_ADD3;
    sb.push_back(mk("add3", ALU_ADD, 32'd5, 32'd7, 32'd7, 5'd3, 1, 0, 0, 0, 1));
    cyc("add3", 1, 0, 0);
    if_instr = I_LW4;
    sb.push_back(mk("lw4", ALU_ADD, 32'd5, 32'hFFFF_FFFC, 32'd9, 5'd4, 1, 1, 0, 0, 1));
    cyc("lw4", 1, 1, 0);
    if_instr = I_ADD5;
    cyc("loaduse_stall", 0, 1, 0);
    sb.push_back(mk("add5", ALU_ADD, 32'd9, 32'd7, 32'd7, 5'd5, 1, 0, 0, 0, 1));
    cyc("loaduse_bubble", 1, 0, 0);

    // back-pressure
    if_instr = I_ADD6;
    sb.push_back(mk("add6", ALU_ADD, 32'd5, 32'd7, 32'd7, 5'd6, 1, 0, 0, 0, 1));
    cyc("add6", 1, 1, 0);
    ex_ready = 1'b0; if_instr = I_ADD7;
    for (int i = 0; i < 3; i++) cyc("backpressure", 0, 1, 0);
    ex_ready = 1'b1;
    sb.push_back(mk("add7", ALU_ADD, 32'd7, 32'd5, 32'd5, 5'd7, 1, 0, 0, 0, 1));
    cyc("add7", 1, 1, 0);

    // bypass
    rf[1] = '0; wb_write = 1'b1; wb_reg = 5'd1; wb_data = 32'h0000_DEAD;
    if_instr = I_ADDI;
    sb.push_back(mk("addi_byp", ALU_ADD, 32'h0000_DEAD, 32'd1, 32'd7, 5'd2, 1, 0, 0, 0, 1));
    cyc("addi_byp", 1, 1, 0);
    wb_reg = 5'd0;
    sb.push_back(mk("addi_nobyp", ALU_ADD, 32'd0, 32'd1, 32'd7, 5'd2, 1, 0, 0, 0, 1));
    cyc("addi_nobyp", 1, 1, 0);
    wb_write = 1'b0; rf[1] = 32'd5; rf[0] = 32'h0000_1234;

    // mixed ALU ops, store, $0 destination and $0 source
    vec_instr[0] = 32'hAC22_0008;
    vec_exp[0]   = mk("sw", ALU_ADD, 32'd5, 32'd8, 32'd7, 5'd0, 0, 0, 1, 0, 1);
    vec_instr[1] = 32'h0041_4022;
    vec_exp[1]   = mk("sub8", ALU_SUB, 32'd7, 32'd5, 32'd5, 5'd8, 1, 0, 0, 0, 1);
    vec_instr[2] = 32'h0022_482A;
    vec_exp[2]   = mk("slt9", ALU_SLT, 32'd5, 32'd7, 32'd7, 5'd9, 1, 0, 0, 0, 1);
    vec_instr[3] = 32'h0022_5024;
    vec_exp[3]   = mk("and10", ALU_AND, 32'd5, 32'd7, 32'd7, 5'd10, 1, 0, 0, 0, 1);
    vec_instr[4] = 32'h0022_5825;
    vec_exp[4]   = mk("or11", ALU_OR, 32'd5, 32'd7, 32'd7, 5'd11, 1, 0, 0, 0, 1);
    vec_instr[5] = 32'h0002_6020;
    vec_exp[5]   = mk("add12_r0", ALU_ADD, 32'd0, 32'd7, 32'd7, 5'd12, 1, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      if_instr = vec_instr[i];
      sb.push_back(vec_exp[i]);
      cyc(vec_exp[i].nm, 1, 1, 0);
    end
    if_instr = 32'h0022_0020;
    sb.push_back(mk("add_r0dst", ALU_ADD, 32'd5, 32'd7, 32'd7, 5'd0, 0, 0, 0, 0, 1));
    cyc("add_r0dst", 1, 1, 0);

    // illegal opcode, then flush while held
    if_instr = I_ILL;
    sb.push_back(mk("illegal", ALU_NOP, 32'd5, 32'd0, 32'd7, 5'd0, 0, 0, 0, 1, 0));
    cyc("illegal", 1, 1, 0);
    ex_ready = 1'b0; if_valid = 1'b0;
    cyc("ill_held", 0, 1, 0);
    flush = 1'b1; if_valid = 1'b1; if_instr = I_ADD3;
    cyc("flush_held", 0, 1, 0);
    flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1; drop = 1'b1;
    cyc("after_flush", 1, 0, 0);
    drop = 1'b0;
    flush = 1'b1; if_valid = 1'b1; if_instr = I_ADD3;
    cyc("flush_vs_accept", 0, 0, 0);
    flush = 1'b0; if_valid = 1'b0;
    cyc("no_accept_on_flush", 1, 0, 0);

    // reset while stalled with a held load
    if_valid = 1'b1; if_instr = I_LW4Z;
    sb.push_back(mk("lw4z", ALU_ADD, 32'd5, 32'd0, 32'd9, 5'd4, 1, 1, 0, 0, 1));
    cyc("lw4z", 1, 0, 0);
    ex_ready = 1'b0; if_instr = I_ADD5;
    cyc("stall_held", 0, 1, 0);
    reset_b = 1'b0;
    cyc("reset_req", 0, 1, 0);
    drop = 1'b1;
    cyc("reset_mid_stall", 0, -1, 1);
    drop = 1'b0; reset_b = 1'b1; ex_ready = 1'b1;
    sb.push_back(mk("add5_post_rst", ALU_ADD, 32'd9, 32'd7, 32'd7, 5'd5, 1, 0, 0, 0, 1));
    cyc("first_accept", 1, 0, 0);
    if_valid = 1'b0;
    cyc("drain", 1, 1, 0);
    cyc("tail", 1, 0, 0);

    exp_rdy = -1; exp_v = -1; exp_zero = 0;
    done = 1'b1;
    forever @(posedge clk);
  end

endmodule
